// File: rtl/ft245_dev_pkg.sv
// ----------------------------------------------------------------------------
// ft245_dev_pkg
// Shared constants for the FTDI-side synchronous FT245 model.
//   FT_BUS_W       : width of the FT245 data bus and of the USB byte streams
//   FLAG_ACTIVE    : level of ft_rxf_n / ft_txe_n when the flag is asserted
//   FLAG_INACTIVE  : level of ft_rxf_n / ft_txe_n when the flag is deasserted
//   ft_byte_t      : one bus/stream byte
// ----------------------------------------------------------------------------
package ft245_dev_pkg;

    localparam int   FT_BUS_W      = 8;
    localparam logic FLAG_ACTIVE   = 1'b0;
    localparam logic FLAG_INACTIVE = 1'b1;

    typedef logic [FT_BUS_W-1:0] ft_byte_t;

endpackage

// File: rtl/sync_ft245_device_if.sv
// ----------------------------------------------------------------------------
// sync_ft245_device_if
// Groups the FT245 strobes/flags, the two USB-side byte streams and the sticky
// error flags of sync_ft245_device. The tristate data bus is kept as a plain
// inout on the device so that the tristate resolves at a module boundary.
//   slave  : the FTDI-side device (drives flags, usb_rx_ready, usb_tx_*, errs)
//   master : the environment (FPGA controller strobes + USB host side)
// Stream handshakes: a byte moves on a rising edge where valid and ready are
// both high; valid must not depend on ready, and data is only meaningful while
// valid is high.
// ----------------------------------------------------------------------------
interface sync_ft245_device_if;
    import ft245_dev_pkg::*;

    // FT245 pins (except the data bus)
    logic     ft_rxf_n;
    logic     ft_txe_n;
    logic     ft_rd_n;
    logic     ft_wr_n;
    logic     ft_oe_n;
    logic     ft_siwu_n;

    // host -> FPGA stream, loaded into the RX FIFO
    ft_byte_t usb_rx_data;
    logic     usb_rx_valid;
    logic     usb_rx_ready;

    // FPGA -> host stream, drained from the TX FIFO
    ft_byte_t usb_tx_data;
    logic     usb_tx_valid;
    logic     usb_tx_ready;

    // sticky protocol error flags
    logic     err_overflow;
    logic     err_underflow;

    modport slave (
        input  ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n,
        input  usb_rx_data, usb_rx_valid, usb_tx_ready,
        output ft_rxf_n, ft_txe_n,
        output usb_rx_ready, usb_tx_data, usb_tx_valid,
        output err_overflow, err_underflow
    );

    modport master (
        output ft_rd_n, ft_wr_n, ft_oe_n, ft_siwu_n,
        output usb_rx_data, usb_rx_valid, usb_tx_ready,
        input  ft_rxf_n, ft_txe_n,
        input  usb_rx_ready, usb_tx_data, usb_tx_valid,
        input  err_overflow, err_underflow
    );

endinterface

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO used for both directions of the FT245 model.
// Parameters:
//   DEPTH : number of entries, power of 2 and >= 2
//   W     : data width
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset (flushes the FIFO)
//   i_push, i_data : write request and data; ignored while full
//   i_pop          : read request; ignored while empty
//   o_data         : head entry, valid whenever o_count != 0
//   o_count        : registered occupancy (AW+1 bits)
//   o_count_next   : occupancy after the current edge's push/pop
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_data,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [$clog2(DEPTH):0] o_count_next
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // Guard here as well so the FIFO can never corrupt itself, whatever the
    // caller's gating looks like.
    assign w_push = i_push && (r_count != FULL_CNT);
    assign w_pop  = i_pop  && (r_count != '0);

    always_comb begin
        o_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   o_count_next = r_count + CNT_ONE;
            2'b01:   o_count_next = r_count - CNT_ONE;
            default: o_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= o_count_next;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/sync_ft245_device.sv
// ----------------------------------------------------------------------------
// sync_ft245_device
// FTDI-chip side of the synchronous FT245 FIFO interface. Buffers bytes
// between two USB-side valid/ready streams and the FT245 pins.
// Parameters:
//   DEPTH : entries per FIFO (RX and TX), power of 2 and >= 2
// Ports:
//   ft_clkout : the single clock, rising edge
//   rst       : synchronous active-high reset
//   ft_bus    : FT245 data bus, driven only while ft_oe_n=0 and not in reset
//   bus_if    : sync_ft245_device_if.slave (strobes, flags, USB streams, errs)
// Optional build macro:
//   FT245_DEV_CHECK_EN : adds simulation-only protocol checks and ft_siwu_n
//                        logging; without it ft_siwu_n is ignored.
// ----------------------------------------------------------------------------
module sync_ft245_device
    import ft245_dev_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                ft_clkout,
    input  logic                rst,
    inout  wire  [FT_BUS_W-1:0] ft_bus,
    sync_ft245_device_if.slave  bus_if
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    ft_byte_t    w_rx_head;
    ft_byte_t    w_tx_head;
    logic [AW:0] w_rx_count;
    logic [AW:0] w_rx_count_next;
    logic [AW:0] w_tx_count;
    logic [AW:0] w_tx_count_next;
    logic        w_rx_ready;
    logic        w_tx_valid;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_bus_drive;

    logic        r_rxf_n;
    logic        r_txe_n;
    logic        r_err_overflow;
    logic        r_err_underflow;

    // RX path: USB host -> FIFO -> FT245 bus
    assign w_rx_ready = (w_rx_count != FULL_CNT);
    assign w_rx_push  = bus_if.usb_rx_valid && w_rx_ready;
    assign w_rx_pop   = !bus_if.ft_rd_n && !bus_if.ft_oe_n && (r_rxf_n == FLAG_ACTIVE);

    // TX path: FT245 bus -> FIFO -> USB host
    assign w_tx_push  = !bus_if.ft_wr_n && (r_txe_n == FLAG_ACTIVE);
    assign w_tx_valid = (w_tx_count != '0);
    assign w_tx_pop   = w_tx_valid && bus_if.usb_tx_ready;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (FT_BUS_W)
    ) u_rx_fifo (
        .i_clk        (ft_clkout),
        .i_rst        (rst),
        .i_push       (w_rx_push),
        .i_pop        (w_rx_pop),
        .i_data       (bus_if.usb_rx_data),
        .o_data       (w_rx_head),
        .o_count      (w_rx_count),
        .o_count_next (w_rx_count_next)
    );

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (FT_BUS_W)
    ) u_tx_fifo (
        .i_clk        (ft_clkout),
        .i_rst        (rst),
        .i_push       (w_tx_push),
        .i_pop        (w_tx_pop),
        .i_data       (ft_bus),
        .o_data       (w_tx_head),
        .o_count      (w_tx_count),
        .o_count_next (w_tx_count_next)
    );

    // Flags are loaded from count_next so they already reflect this edge's
    // traffic; a controller sampling them on the falling edge cannot overrun.
    always_ff @(posedge ft_clkout) begin
        if (rst) begin
            r_rxf_n <= FLAG_INACTIVE;
            r_txe_n <= FLAG_INACTIVE;
        end else begin
            r_rxf_n <= (w_rx_count_next == '0)      ? FLAG_INACTIVE : FLAG_ACTIVE;
            r_txe_n <= (w_tx_count_next == FULL_CNT) ? FLAG_INACTIVE : FLAG_ACTIVE;
        end
    end

    // Sticky errors: any strobe seen while its flag says "not allowed".
    // Strobes during reset are ignored.
    always_ff @(posedge ft_clkout) begin
        if (rst) begin
            r_err_overflow  <= 1'b0;
            r_err_underflow <= 1'b0;
        end else begin
            if (!bus_if.ft_wr_n && (r_txe_n == FLAG_INACTIVE)) begin
                r_err_overflow <= 1'b1;
            end
            if (!bus_if.ft_rd_n && (r_rxf_n == FLAG_INACTIVE)) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    // Released during reset as well, so a flushed FIFO never drives stale data.
    assign w_bus_drive = !bus_if.ft_oe_n && !rst;
    assign ft_bus      = w_bus_drive ? w_rx_head : 'z;

    assign bus_if.ft_rxf_n      = r_rxf_n;
    assign bus_if.ft_txe_n      = r_txe_n;
    assign bus_if.usb_rx_ready  = w_rx_ready;
    assign bus_if.usb_tx_valid  = w_tx_valid;
    assign bus_if.usb_tx_data   = w_tx_head;
    assign bus_if.err_overflow  = r_err_overflow;
    assign bus_if.err_underflow = r_err_underflow;

`ifdef FT245_DEV_CHECK_EN
    always_ff @(posedge ft_clkout) begin
        if (!rst) begin
            if (!bus_if.ft_rd_n && bus_if.ft_oe_n) begin
                $error("ft245_dev: ft_rd_n low while ft_oe_n high");
            end
            if (!bus_if.ft_wr_n && !bus_if.ft_oe_n) begin
                $error("ft245_dev: ft_wr_n low while ft_oe_n low");
            end
            if (!bus_if.ft_rd_n && (r_rxf_n == FLAG_INACTIVE)) begin
                $error("ft245_dev: read strobe while ft_rxf_n inactive");
            end
            if (!bus_if.ft_wr_n && (r_txe_n == FLAG_INACTIVE)) begin
                $error("ft245_dev: write strobe while ft_txe_n inactive");
            end
            if (w_tx_push && $isunknown(ft_bus)) begin
                $error("ft245_dev: unknown value on ft_bus during a write");
            end
            if (!bus_if.ft_siwu_n) begin
                $info("ft245_dev: send-immediate, tx count=%0d", w_tx_count);
            end
        end
    end
`else
    // Send-immediate and the TX occupancy only feed the checker.
    logic w_unused_ok;
    assign w_unused_ok = ^{bus_if.ft_siwu_n, w_tx_count};
`endif

endmodule

// File: tb/tb_sync_ft245_device.sv
// ----------------------------------------------------------------------------
// tb_sync_ft245_device
// Directed + randomized bench for sync_ft245_device (default build, DEPTH=16).
// A queue-based reference model of both FIFOs, the flag registers and the
// sticky error flags is advanced once per rising edge from the inputs that
// edge sees; DUT outputs are compared 1 time unit after each edge.
// ----------------------------------------------------------------------------
module tb_sync_ft245_device;
    import ft245_dev_pkg::*;

    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT hookup ----------------
    wire  [7:0] ft_bus;
    logic [7:0] tb_bus_d;
    logic       tb_bus_en;
    assign ft_bus = tb_bus_en ? tb_bus_d : 8'hzz;

    sync_ft245_device_if bus_if();

    sync_ft245_device #(
        .DEPTH (DEPTH)
    ) dut (
        .ft_clkout (clk),
        .rst       (rst),
        .ft_bus    (ft_bus),
        .bus_if    (bus_if)
    );

    // ---------------- reference model ----------------
    logic [7:0] m_rx_q[$];
    logic [7:0] m_tx_q[$];
    logic       m_rxf_n = 1'b1;
    logic       m_txe_n = 1'b1;
    logic       m_ovf   = 1'b0;
    logic       m_unf   = 1'b0;

    // scoreboard for the loopback phase
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model with the inputs present before the edge, then take
    // the edge and settle.
    task automatic step();
        logic rx_push, rx_pop, tx_push, tx_pop;
        logic [7:0] d;
        if (rst) begin
            m_rx_q.delete();
            m_tx_q.delete();
            m_rxf_n = 1'b1;
            m_txe_n = 1'b1;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            rx_push = bus_if.usb_rx_valid && (m_rx_q.size() < DEPTH);
            rx_pop  = !bus_if.ft_rd_n && !bus_if.ft_oe_n && !m_rxf_n;
            tx_push = !bus_if.ft_wr_n && !m_txe_n;
            tx_pop  = (m_tx_q.size() > 0) && bus_if.usb_tx_ready;
            if (!bus_if.ft_wr_n && m_txe_n) m_ovf = 1'b1;
            if (!bus_if.ft_rd_n && m_rxf_n) m_unf = 1'b1;
            if (rx_pop)  d = m_rx_q.pop_front();
            if (rx_push) m_rx_q.push_back(bus_if.usb_rx_data);
            if (tx_pop)  d = m_tx_q.pop_front();
            if (tx_push) m_tx_q.push_back(tb_bus_d);
            m_rxf_n = (m_rx_q.size() == 0);
            m_txe_n = (m_tx_q.size() == DEPTH);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_rxf_n"},    bus_if.ft_rxf_n,      m_rxf_n);
        chk({tag, "_txe_n"},    bus_if.ft_txe_n,      m_txe_n);
        chk({tag, "_rx_ready"}, bus_if.usb_rx_ready,  m_rx_q.size() < DEPTH);
        chk({tag, "_tx_valid"}, bus_if.usb_tx_valid,  m_tx_q.size() > 0);
        chk({tag, "_ovf"},      bus_if.err_overflow,  m_ovf);
        chk({tag, "_unf"},      bus_if.err_underflow, m_unf);
        if (m_tx_q.size() > 0) chk({tag, "_tx_data"}, bus_if.usb_tx_data, m_tx_q[0]);
        if (tb_bus_en) begin
            chk({tag, "_bus_released"}, ft_bus, tb_bus_d);
        end else if (!bus_if.ft_oe_n && !rst && (m_rx_q.size() > 0)) begin
            chk({tag, "_bus_head"}, ft_bus, m_rx_q[0]);
        end
    endtask

    task automatic idle_pins();
        bus_if.ft_rd_n      = 1'b1;
        bus_if.ft_wr_n      = 1'b1;
        bus_if.ft_oe_n      = 1'b1;
        bus_if.usb_rx_valid = 1'b0;
        bus_if.usb_tx_ready = 1'b0;
        tb_bus_en           = 1'b1;
        tb_bus_d            = 8'h3C;
    endtask

    task automatic do_reset(input int n);
        idle_pins();
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            check_model("rst");
        end
        rst = 1'b0;
        step();
        check_model("rst_rel");
    endtask

    task automatic drain_tx(input string tag);
        bus_if.ft_wr_n      = 1'b1;
        bus_if.usb_tx_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH && m_tx_q.size() > 0; i++) begin
            step();
            check_model(tag);
        end
        bus_if.usb_tx_ready = 1'b0;
        chk({tag, "_empty"}, bus_if.usb_tx_valid, 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int wi;
        int cyc;
        bit do_rd;

        bus_if.ft_siwu_n   = 1'b1;
        bus_if.usb_rx_data = 8'h00;
        idle_pins();

        // Reset held 3 cycles with ft_oe_n and ft_rd_n low: bus stays
        // released, flags inactive, no error from the read strobe.
        rst            = 1'b1;
        bus_if.ft_oe_n = 1'b0;
        bus_if.ft_rd_n = 1'b0;
        tb_bus_d       = 8'h5A;
        #1;
        chk("reset_bus_z_early", ft_bus, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            step();
            check_model("reset");
            chk("reset_rxf_n", bus_if.ft_rxf_n, 1'b1);
            chk("reset_txe_n", bus_if.ft_txe_n, 1'b1);
            chk("reset_rx_ready", bus_if.usb_rx_ready, 1'b1);
        end
        rst            = 1'b0;
        bus_if.ft_rd_n = 1'b1;
        bus_if.ft_oe_n = 1'b1;
        step();
        check_model("post_reset");
        chk("post_reset_txe_n", bus_if.ft_txe_n, 1'b0);
        chk("post_reset_unf", bus_if.err_underflow, 1'b0);

        // RX burst: 0x01..0x10 from USB, one more while full is refused.
        bus_if.usb_rx_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus_if.usb_rx_data = 8'(i + 1);
            step();
            check_model("rx_fill");
        end
        chk("rx_full_ready", bus_if.usb_rx_ready, 1'b0);
        chk("rx_full_rxf_n", bus_if.ft_rxf_n, 1'b0);
        bus_if.usb_rx_data = 8'h99;
        step();
        check_model("rx_blocked");
        bus_if.usb_rx_valid = 1'b0;

        bus_if.ft_oe_n = 1'b0;
        tb_bus_en      = 1'b0;
        #1;
        chk("rx_first_head", ft_bus, 8'h01);
        for (int i = 0; i < DEPTH; i++) begin
            bus_if.ft_rd_n = 1'b0;
            chk("rx_read_byte", ft_bus, 8'(i + 1));
            step();
            check_model("rx_read");
        end
        bus_if.ft_rd_n = 1'b1;
        chk("rx_empty_rxf_n", bus_if.ft_rxf_n, 1'b1);
        chk("rx_burst_unf", bus_if.err_underflow, 1'b0);
        bus_if.ft_oe_n = 1'b1;
        tb_bus_en      = 1'b1;

        // TX fill: 0xA0..0xAF with the host stalled, then a forced 17th write.
        bus_if.usb_tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tb_bus_d       = 8'hA0 + 8'(i);
            bus_if.ft_wr_n = 1'b0;
            step();
            check_model("tx_fill");
        end
        chk("tx_full_txe_n", bus_if.ft_txe_n, 1'b1);
        tb_bus_d = 8'hEE;
        step();
        bus_if.ft_wr_n = 1'b1;
        check_model("tx_over");
        chk("tx_overflow_set", bus_if.err_overflow, 1'b1);
        bus_if.usb_tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("tx_content", bus_if.usb_tx_data, 8'hA0 + 8'(i));
            step();
            check_model("tx_drain");
        end
        bus_if.usb_tx_ready = 1'b0;
        chk("tx_drained_valid", bus_if.usb_tx_valid, 1'b0);
        chk("tx_overflow_sticky", bus_if.err_overflow, 1'b1);

        // Simultaneous push/pop on TX holding 8 bytes for 20 cycles.
        for (int i = 0; i < 8; i++) begin
            tb_bus_d       = 8'($urandom_range(0, 255));
            bus_if.ft_wr_n = 1'b0;
            step();
            check_model("sim_prefill");
        end
        bus_if.usb_tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tb_bus_d = 8'($urandom_range(0, 255));
            step();
            check_model("sim_stream");
            chk("sim_txe_n", bus_if.ft_txe_n, 1'b0);
            chk("sim_valid", bus_if.usb_tx_valid, 1'b1);
        end
        drain_tx("sim_drain");

        // Read strobe on an empty RX FIFO.
        bus_if.ft_oe_n = 1'b0;
        tb_bus_en      = 1'b0;
        bus_if.ft_rd_n = 1'b0;
        step();
        bus_if.ft_rd_n = 1'b1;
        check_model("underflow");
        chk("underflow_set", bus_if.err_underflow, 1'b1);
        bus_if.ft_oe_n = 1'b1;
        tb_bus_en      = 1'b1;

        // Random mixed traffic in both directions.
        for (int c = 0; c < 300; c++) begin
            bus_if.ft_oe_n = 1'($urandom_range(0, 1));
            if (!bus_if.ft_oe_n) begin
                tb_bus_en      = 1'b0;
                bus_if.ft_wr_n = 1'b1;
                bus_if.ft_rd_n = ($urandom_range(0, 3) == 0);
            end else begin
                tb_bus_en      = 1'b1;
                tb_bus_d       = 8'($urandom_range(0, 255));
                bus_if.ft_rd_n = 1'b1;
                bus_if.ft_wr_n = ($urandom_range(0, 2) == 0);
            end
            bus_if.usb_rx_valid = 1'($urandom_range(0, 1));
            bus_if.usb_rx_data  = 8'($urandom_range(0, 255));
            bus_if.usb_tx_ready = 1'($urandom_range(0, 1));
            step();
            check_model("rand");
        end

        // Reset for one cycle in the middle of an RX burst (at byte 5).
        do_reset(2);
        bus_if.usb_rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_if.usb_rx_data = 8'h11 + 8'(i);
            step();
            check_model("mid_fill");
        end
        bus_if.usb_rx_valid = 1'b0;
        bus_if.ft_oe_n      = 1'b0;
        tb_bus_en           = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_if.ft_rd_n = 1'b0;
            step();
            check_model("mid_read");
        end
        chk("mid_byte5", ft_bus, 8'h15);
        rst       = 1'b1;
        tb_bus_en = 1'b1;
        tb_bus_d  = 8'hC3;
        #1;
        chk("mid_rst_bus_z", ft_bus, 8'hC3);
        step();
        check_model("mid_rst");
        chk("mid_rst_rxf_n", bus_if.ft_rxf_n, 1'b1);
        chk("mid_rst_unf", bus_if.err_underflow, 1'b0);
        rst            = 1'b0;
        bus_if.ft_rd_n = 1'b1;
        bus_if.ft_oe_n = 1'b1;
        step();
        check_model("mid_rel");
        chk("mid_rel_rxf_n", bus_if.ft_rxf_n, 1'b1);
        chk("mid_rel_txe_n", bus_if.ft_txe_n, 1'b0);
        chk("mid_rel_ovf", bus_if.err_overflow, 1'b0);

        // Loopback: host side echoes usb_tx into usb_rx; 256 random bytes.
        for (int i = 0; i < 256; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        wi  = 0;
        cyc = 0;
        while (got_q.size() < 256 && cyc < 4000) begin
            bus_if.usb_rx_data  = bus_if.usb_tx_data;
            bus_if.usb_rx_valid = bus_if.usb_tx_valid;
            bus_if.usb_tx_ready = bus_if.usb_rx_ready;
            do_rd = !bus_if.ft_rxf_n && ((wi >= 256) || bus_if.ft_txe_n || ($urandom_range(0, 1) == 1));
            if (do_rd) begin
                bus_if.ft_oe_n = 1'b0;
                bus_if.ft_wr_n = 1'b1;
                bus_if.ft_rd_n = 1'b0;
                tb_bus_en      = 1'b0;
                #1;
                got_q.push_back(ft_bus);
            end else if (wi < 256 && !bus_if.ft_txe_n) begin
                bus_if.ft_oe_n = 1'b1;
                bus_if.ft_rd_n = 1'b1;
                tb_bus_en      = 1'b1;
                tb_bus_d       = exp_q[wi];
                bus_if.ft_wr_n = 1'b0;
                wi++;
            end else begin
                bus_if.ft_oe_n = 1'b1;
                bus_if.ft_rd_n = 1'b1;
                bus_if.ft_wr_n = 1'b1;
                tb_bus_en      = 1'b1;
                tb_bus_d       = 8'($urandom_range(0, 255));
            end
            step();
            check_model("loop");
            cyc++;
        end
        idle_pins();
        chk("loop_count", got_q.size(), 256);
        for (int i = 0; i < 256; i++) begin
            if (i < got_q.size()) chk("loop_byte", got_q[i], exp_q[i]);
        end
        chk("loop_ovf", bus_if.err_overflow, 1'b0);
        chk("loop_unf", bus_if.err_underflow, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
